// File: rtl/demux_1_4_stream_if.sv
// Stream bundle for the 1-to-4 demux: one valid/ready input, four valid/ready outputs.
// slave is the demux view; master is the producer/consumer-side view.
interface demux_1_4_stream_if #(parameter int WIDTH = 4);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         in_sel;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux_1_4_stream.sv
// Registered 1-to-4 stream demux with a one-entry holding register per channel.
// Optional macro DEMUX_ROUND_ROBIN_EN: destination comes from an internal pointer instead of in_sel.
module demux_1_4_stream #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  demux_1_4_stream_if.slave  bus
);

  logic [1:0]            dest;
  logic [3:0]            slot_free;
  logic                  accept;
  logic [3:0]            valid_q;
  logic [3:0][WIDTH-1:0] data_q;

`ifdef DEMUX_ROUND_ROBIN_EN
  logic [1:0] ptr;

  // Strict order: the pointer only moves on an accept, so a full target stalls the input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 2'd0;
    end else if (accept) begin
      ptr <= ptr + 2'd1;
    end
  end

  assign dest = ptr;
`else
  assign dest = bus.in_sel;
`endif

  // A slot draining this cycle can take new data on the same edge.
  assign slot_free    = ~valid_q | bus.out_ready;
  assign bus.in_ready = slot_free[dest];
  assign accept       = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 4'b0000;
      data_q  <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (accept && (dest == 2'(k))) begin
          valid_q[k] <= 1'b1;
          data_q[k]  <= bus.in_data;
        end else if (valid_q[k] && bus.out_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;

endmodule

// File: doc/demux_1_4_stream.md
# demux_1_4_stream

Registered 1-to-4 stream demultiplexer, the counterpart of the 4:1 data mux: one WIDTH-bit valid/ready input stream is steered to one of four output channels by a 2-bit select. Each output channel has a one-entry holding register, so a stalled channel blocks only transfers addressed to it. The block sits between a single producer and four independent consumers.

## Interface

- WIDTH, default 4: data width in bits per channel; WIDTH ≥ 1.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  input transfer request.
- in_ready  output  1  block can accept the input this cycle; combinational.
- in_data  input  WIDTH  input payload.
- in_sel  input  2  destination channel 0..3; sampled with in_data; ignored when DEMUX_ROUND_ROBIN_EN is defined.
- out_valid  output  4  bit k: channel k holds valid data.
- out_ready  input  4  bit k: consumer k accepts this cycle.
- out_data  output  4*WIDTH  channel k payload in bits [k*WIDTH +: WIDTH].

## Operation

- Destination d = in_sel (select mode) or ptr (round-robin mode, 2-bit internal pointer).
- Slot k is free when out_valid[k]==0 or out_ready[k]==1.
- in_ready = slot d free. No dependence on in_valid.
- Accept = in_valid & in_ready: at clock edge, out_data[d] <= in_data, out_valid[d] <= 1.
- Drain of channel k = out_valid[k] & out_ready[k]: if not reloaded same edge, out_valid[k] <= 0; out_data[k] keeps last value.
- Simultaneous drain and accept on the same channel: new data loaded, out_valid[k] stays 1 (full throughput per channel).
- Accept on channel d with drain on channel k≠d in the same cycle: both take effect independently.
- Channels other than d are never written; their data and valid are unaffected by in_sel changes.
- out_data[k] stable while out_valid[k] & !out_ready[k].
- in_valid with in_ready==0: nothing happens; producer holds request (no drop, no queuing).
- out_ready[k] while out_valid[k]==0: no effect.
- Round-robin pointer: increments modulo 4 on every accept only (3 -> 0 wrap); holds otherwise.

## Timing

- Reset (async assert, any time, including mid-transfer): out_valid = 4'b0000, out_data = all zeros, ptr = 0 immediately; in_ready = 1 while rst deasserted and slots empty. In-flight data discarded.
- Latency: input accepted at edge N -> out_valid[d]=1 and out_data[d] valid after edge N, visible in cycle N+1.
- Throughput: one transfer per cycle when target consumer keeps out_ready high; back-to-back to the same channel sustained.
- in_ready is combinational from in_sel (or ptr), out_valid[d], out_ready[d]; no combinational path from in_valid to in_ready.
- Outputs out_valid/out_data are registered; no combinational input-to-output path on data.

## Configuration

- DEMUX_ROUND_ROBIN_EN defined: in_sel ignored; destination is internal ptr, cycling 0,1,2,3,0 on each accept; stall on a full target channel stalls the whole input (strict order, no skipping).
- Not defined: destination = in_sel every cycle; no pointer register synthesized; ptr behaviour irrelevant.

## Test plan

- Reset: assert rst mid-cycle with out_valid=4'b0101 -> out_valid=4'b0000, out_data all zero immediately, in_ready=1 after release.
- Steering: out_ready=4'b1111; send data 'ha,'hb,'hc,'hd with in_sel 0,1,2,3 on consecutive cycles -> channel k shows its value one cycle after accept, out_valid one-hot pulse per channel.
- Backpressure: out_ready[2]=0; send 'h7 to sel 2, then 'h3 to sel 2 -> second held with in_ready=0, out_data[2] stays 'h7; raise out_ready[2] -> 'h3 accepted same cycle, appears next cycle.
- Independence: channel 1 stalled holding 'h5; send 'h9 to sel 3 -> accepted immediately, channel 1 unchanged.
- Simultaneous drain+load: channel 0 holds 'h1, out_ready[0]=1, in_valid with 'h2 sel 0 -> out_valid[0] stays 1, out_data[0]='h2 next cycle.
- Round-robin (DEMUX_ROUND_ROBIN_EN): in_sel held at 0, send 'ha,'hb,'hc,'hd,'he -> channels 0,1,2,3,0 receive them; stall channel 1 -> in_ready=0, ptr holds at 1.
